dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter WIDTH, default 48, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 64, number of words; SHALL be a power of 2.
REQ-003 Parameter STRIDE, default 4, byte distance between consecutive word addresses; SHALL be a power of 2.
REQ-004 Parameter AW, default 32, address width in bits.
REQ-005 Ports SHALL be, in order:
  CLK    in   1             single clock; all state changes on rising edge
  RST    in   1             reset, synchronous, active-high
  REQ    in   1             request valid
  READY  out  1             controller accepts REQ this cycle
  WE     in   1             1 = write, 0 = read
  A      in   AW            byte address
  WD     in   WIDTH         write data
  BE     in   WIDTH/8       byte-lane write enables
  RVALID out  1             one-cycle response strobe
  RD     out  WIDTH         read data
  ERR    out  1             response error flag, qualified by RVALID

Function
REQ-006 States SHALL be INIT and IDLE; a request is accepted when REQ && READY at a rising edge.
REQ-007 INIT: READY=0; an internal counter writes zero to word[cnt] each cycle from 0 to DEPTH-1; after the DEPTH-1 write the state SHALL become IDLE, so INIT lasts exactly DEPTH cycles.
REQ-008 IDLE: READY=1 continuously; one request accepted per cycle, back-to-back without bubbles.
REQ-009 Word index SHALL be A >> log2(STRIDE); the access is misaligned if A mod STRIDE != 0 and out-of-range if index >= DEPTH.
REQ-010 An accepted write with a valid address SHALL update only the bytes whose BE bit is 1, at the accepting edge.
REQ-011 Every accepted request SHALL produce RVALID=1 for exactly one cycle, the cycle after acceptance (latency 1).
REQ-012 Read response: RD = stored word, ERR=0; write response: RD = 0, ERR=0.
REQ-013 Misaligned or out-of-range request: no storage change, response RD=0, ERR=1.
REQ-014 A read in the cycle after a write to the same word SHALL return the newly written bytes.
REQ-015 When RVALID=0, RD and ERR SHALL be 0.
REQ-016 Requests presented while READY=0 SHALL be ignored and produce no response.

Reset
REQ-017 RST=1 at a rising edge SHALL set state INIT, counter 0, READY=0, RVALID=0, RD=0, ERR=0.
REQ-018 Reset mid-operation SHALL drop any pending response (no RVALID after the reset edge) and restart the full DEPTH-cycle clear.
REQ-019 RST held high SHALL keep the block in the reset values; clearing starts on the first edge with RST=0.

Configuration
REQ-020 Macro DMEM_PARITY_EN: when defined, one even-parity bit per byte lane SHALL be stored with each written byte (INIT stores parity of zero) and checked on read; any mismatch SHALL give ERR=1 with RD still returning the stored data.
REQ-021 With DMEM_PARITY_EN, an extra input PINJ (1 bit) SHALL invert the stored parity bits of the enabled lanes of the accepted write; without the macro PINJ and parity storage SHALL not exist and ERR reflects address faults only.

Structure
REQ-022 Package dmem_pkg SHALL hold the state enum typedef (INIT, IDLE) and the parity-width helper function.
REQ-023 Sub-module dmem_array SHALL hold the storage: byte-enable synchronous write, synchronous 1-cycle read; dmem_ctrl holds the state machine, address checks, clear counter and response register.

Verification (WIDTH=48, DEPTH=64, STRIDE=4)
REQ-024 Reset release -> READY=0 for 64 cycles then 1; reads of A=0 and A=252 return RD=0, ERR=0.
REQ-025 Write A=i, WD=i, BE=6'h3F for i=0..252 step 4, back-to-back -> 64 RVALID pulses; then reads A=0..252 return RD=i each, ERR=0, one response per cycle.
REQ-026 Write A=8, WD=48'hFFFF_FFFF_FFFF, BE=6'h3F, then write A=8, WD=0, BE=6'h05 -> read A=8 returns 48'hFFFF_FF00_FF00.
REQ-027 Request A=6 (misaligned) and A=256 (out-of-range), WE=1 -> RVALID with ERR=1, RD=0; later reads of A=4 and A=252 unchanged.
REQ-028 Assert RST for one cycle during a read stream -> no RVALID after reset edge, READY=0 for 64 cycles, previously written A=16 reads 0.
REQ-029 With DMEM_PARITY_EN: write A=20, PINJ=1, BE=6'h01 -> read A=20 gives ERR=1, RD holds written data; rewrite with PINJ=0 -> ERR=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and lane helper for the data memory controller
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // One parity bit per byte lane.
  function automatic int par_width(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-lane word storage, synchronous write, registered read
// Build option DMEM_PARITY_EN adds one stored parity bit per byte lane.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 64,
  localparam int NB    = par_width(WIDTH),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe,
`ifdef DMEM_PARITY_EN
  input  logic [NB-1:0]    wpar,
  output logic [NB-1:0]    rpar,
`endif
  input  logic             re,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rpar_q, rpar_d;

  always_comb begin
    rpar_d = rpar_q;
    if (re) rpar_d = par_q[raddr];
  end

  always_ff @(posedge clk) begin
    rpar_q <= rpar_d;
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) par_q[waddr][b] <= wpar[b];
      end
    end
  end

  assign rpar = rpar_q;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data memory controller: power-up clear, address checks, 1-cycle responses
// Build option DMEM_PARITY_EN enables per-lane parity storage/check and the PINJ input.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int WIDTH  = 48,
  parameter  int DEPTH  = 64,
  parameter  int STRIDE = 4,
  parameter  int AW     = 32,
  localparam int NB     = par_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  output logic             READY,
  input  logic             WE,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] WD,
  input  logic [NB-1:0]    BE,
  output logic             RVALID,
  output logic [WIDTH-1:0] RD,
  output logic             ERR
`ifdef DMEM_PARITY_EN
  ,
  input  logic             PINJ
`endif
);

  localparam int IW    = $clog2(DEPTH);
  localparam int SHIFT = $clog2(STRIDE);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic          rdsel_q, rdsel_d;

  logic [AW-1:0]    idx_full;
  logic             misaligned, out_of_range, addr_ok, accept;
  logic             arr_we, arr_re;
  logic [IW-1:0]    arr_waddr;
  logic [WIDTH-1:0] arr_wdata, arr_rdata;
  logic [NB-1:0]    arr_wbe;

  always_comb begin
    idx_full     = A >> SHIFT;
    misaligned   = (A & AW'(STRIDE - 1)) != '0;
    out_of_range = idx_full >= AW'(DEPTH);
    addr_ok      = !misaligned && !out_of_range;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdsel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdsel_q  <= rdsel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + IW'(1);
      if (cnt_q == IW'(DEPTH - 1)) state_d = IDLE;
    end
  end

  // During INIT the write port belongs to the clear counter.
  always_comb begin
    READY     = (state_q == IDLE);
    accept    = REQ && READY;
    arr_waddr = idx_full[IW-1:0];
    arr_wdata = WD;
    arr_wbe   = BE;
    arr_re    = accept && !WE && addr_ok;
    arr_we    = accept && WE && addr_ok;
    if (state_q == INIT) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wdata = '0;
      arr_wbe   = '1;
    end
    rvalid_d = accept;
    err_d    = accept && !addr_ok;
    rdsel_d  = accept && !WE && addr_ok;
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] arr_wpar, arr_rpar, par_bad;

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      arr_wpar[b] = (^arr_wdata[b*8 +: 8]) ^ (READY && PINJ);
      par_bad[b]  = (^arr_rdata[b*8 +: 8]) != arr_rpar[b];
    end
  end
`endif

  dmem_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (CLK),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .wbe  (arr_wbe),
`ifdef DMEM_PARITY_EN
    .wpar (arr_wpar),
    .rpar (arr_rpar),
`endif
    .re   (arr_re),
    .raddr(idx_full[IW-1:0]),
    .rdata(arr_rdata)
  );

  always_comb begin
    RVALID = rvalid_q;
    RD     = rdsel_q ? arr_rdata : '0;
    ERR    = err_q;
`ifdef DMEM_PARITY_EN
    if (rdsel_q && (|par_bad)) ERR = 1'b1;
`endif
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard testbench for dmem_ctrl (parity case only with DMEM_PARITY_EN)
module tb_dmem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        READY;
  logic        WE = 1'b0;
  logic [31:0] A = '0;
  logic [47:0] WD = '0;
  logic [5:0]  BE = '0;
  logic        RVALID;
  logic [47:0] RD;
  logic        ERR;
  logic        PINJ = 1'b0;

  dmem_ctrl #(.WIDTH(48), .DEPTH(64), .STRIDE(4), .AW(32)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .READY (READY),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .BE    (BE),
    .RVALID(RVALID),
    .RD    (RD),
    .ERR   (ERR)
`ifdef DMEM_PARITY_EN
    ,
    .PINJ  (PINJ)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [47:0] model [64];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_resp = 0;

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge CLK) begin
    if (RVALID) begin
      n_resp++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rvalid: got RD=%h ERR=%b, required no response", RD, ERR);
      end else begin
        e = exp_q.pop_front();
        if (RD !== e.rd || ERR !== e.err)
          $display("FAIL response: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
        else
          n_pass++;
      end
    end else begin
      n_checks++;
      if (RD !== 48'h0 || ERR !== 1'b0)
        $display("FAIL idle_outputs: got RD=%h ERR=%b, required 0/0", RD, ERR);
      else
        n_pass++;
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [47:0] wd,
                       input logic [5:0] be, input logic [47:0] erd, input logic eerr);
    exp_t x;
    REQ = 1'b1; WE = we; A = a; WD = wd; BE = be;
    x.rd = erd; x.err = eerr;
    exp_q.push_back(x);
    @(posedge CLK); #1;
    REQ = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [47:0] wd, input logic [5:0] be);
    logic ok;
    int   idx;
    ok  = (a[1:0] == 2'b00) && ((a >> 2) < 64);
    idx = int'(a >> 2);
    if (ok)
      for (int b = 0; b < 6; b++)
        if (be[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
    issue(1'b1, a, wd, be, 48'h0, !ok);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic ok;
    ok = (a[1:0] == 2'b00) && ((a >> 2) < 64);
    if (ok) issue(1'b0, a, 48'h0, 6'h0, model[int'(a >> 2)], 1'b0);
    else    issue(1'b0, a, 48'h0, 6'h0, 48'h0, 1'b1);
  endtask

  task automatic settle;
    REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic count_init(output int cnt);
    cnt = 0;
    while (cnt <= 200) begin
      @(negedge CLK);
      if (READY) break;
      cnt++;
    end
    REQ = 1'b0;
  endtask

  task automatic test_reset;
    int cnt;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (READY !== 1'b0 || RVALID !== 1'b0) $display("FAIL reset_state: got READY=%b RVALID=%b, required 0/0", READY, RVALID);
    else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    // Ignored request during the clear must leave word 0 untouched.
    REQ = 1'b1; WE = 1'b1; A = 32'd0; WD = '1; BE = '1;
    count_init(cnt);
    n_checks++;
    if (cnt !== 64) $display("FAIL init_length: got %0d READY-low cycles, required 64", cnt);
    else n_pass++;
    @(posedge CLK); #1;
    do_read(32'd0);
    do_read(32'd252);
    settle();
  endtask

  task automatic test_fill;
    int base;
    base = n_resp;
    for (int i = 0; i <= 252; i += 4) do_write(32'(i), 48'(i), 6'h3F);
    settle();
    n_checks++;
    if (n_resp - base !== 64) $display("FAIL fill_pulses: got %0d, required 64", n_resp - base);
    else n_pass++;
    for (int i = 0; i <= 252; i += 4) issue(1'b0, 32'(i), 48'h0, 6'h0, 48'(i), 1'b0);
    settle();
  endtask

  task automatic test_byte_enable;
    do_write(32'd8, 48'hFFFF_FFFF_FFFF, 6'h3F);
    do_write(32'd8, 48'h0, 6'h05);
    issue(1'b0, 32'd8, 48'h0, 6'h0, 48'hFFFF_FF00_FF00, 1'b0);
    settle();
  endtask

  task automatic test_errors;
    do_write(32'd6, 48'hDEAD_BEEF_0001, 6'h3F);
    do_write(32'd256, 48'hDEAD_BEEF_0002, 6'h3F);
    do_read(32'd2);
    issue(1'b0, 32'd4, 48'h0, 6'h0, 48'd4, 1'b0);
    issue(1'b0, 32'd252, 48'h0, 6'h0, 48'd252, 1'b0);
    settle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      do_write(a, {16'($urandom), 32'($urandom)}, 6'($urandom_range(1, 63)));
      do_read(a);
    end
    settle();
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity;
    PINJ = 1'b1;
    do_write(32'd20, 48'h0000_0000_00A5, 6'h01);
    PINJ = 1'b0;
    issue(1'b0, 32'd20, 48'h0, 6'h0, model[5], 1'b1);
    do_write(32'd20, 48'h0000_0000_00A5, 6'h01);
    do_read(32'd20);
    settle();
  endtask
`endif

  task automatic test_reset_mid;
    int cnt;
    do_write(32'd16, 48'h1234_5678_9ABC, 6'h3F);
    do_read(32'd16);
    do_read(32'd0);
    REQ = 1'b1; WE = 1'b0; A = 32'd16;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    @(negedge CLK);
    n_checks++;
    if (RVALID !== 1'b0 || READY !== 1'b0) $display("FAIL reset_drop: got RVALID=%b READY=%b, required 0/0", RVALID, READY);
    else n_pass++;
    count_init(cnt);
    n_checks++;
    if (cnt + 1 !== 64) $display("FAIL reinit_length: got %0d READY-low cycles, required 64", cnt + 1);
    else n_pass++;
    @(posedge CLK); #1;
    issue(1'b0, 32'd16, 48'h0, 6'h0, 48'h0, 1'b0);
    do_read(32'd0);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_byte_enable();
    test_errors();
    test_back_to_back();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
